present_round_ctrl: RTL and testbench
=====================================

PRESENT_ROUND_CTRL -- requirements
Module: present_round_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 31, meaning the number of full PRESENT rounds (legal range 1..31); all vectors below use 31.
REQ-002 SHALL have port clk, input, 1, meaning rising-edge clock for all state.
REQ-003 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have port din_valid, input, 1, meaning the plaintext/key pair is offered.
REQ-005 SHALL have port din_ready, output, 1, meaning the block accepts a new pair.
REQ-006 SHALL have port plaintext, input, 64, meaning the block to encrypt, bit 63 = MSB.
REQ-007 SHALL have port key, input, 80, meaning the PRESENT-80 user key, bit 79 = MSB.
REQ-008 SHALL have port dout_valid, output, 1, meaning the ciphertext is valid.
REQ-009 SHALL have port dout_ready, input, 1, meaning the consumer takes the ciphertext.
REQ-010 SHALL have port ciphertext, output, 64, meaning the registered encryption result.
REQ-011 SHALL have port busy, output, 1, meaning the block is in RUN.
REQ-012 SHALL have port round_cnt, output, 5, meaning the current round index (0 when not in RUN).

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL drive din_ready high only in IDLE; accept = din_valid & din_ready at a rising edge.
REQ-015 SHALL, on accept, load state_reg <= plaintext, key_reg <= key, round_cnt <= 1, FSM -> RUN.
REQ-016 SHALL, in RUN, perform exactly one round per clock: state_reg <= pLayer(sBoxLayer(state_reg ^ key_reg[79:16])).
REQ-017 SHALL apply the standard PRESENT 4-bit S-box {C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2} to all 16 nibbles.
REQ-018 SHALL implement pLayer as: bit i moves to position 16*i mod 63 for i = 0..62, and bit 63 stays at 63.
REQ-019 SHALL update the key in the same cycle: rotate key_reg left by 61; S-box bits [79:76]; XOR bits [19:15] with round_cnt.
REQ-020 SHALL increment round_cnt by 1 per RUN cycle, as a 5-bit value that never wraps within one operation.
REQ-021 SHALL, on the RUN edge where round_cnt == ROUNDS, load ciphertext <= (round result) ^ (updated key)[79:16], and set FSM -> DONE and round_cnt -> 0.
REQ-022 SHALL give a latency of exactly ROUNDS clock edges from the accept edge to the rise of dout_valid (31 for the default).
REQ-023 SHALL drive dout_valid high only in DONE, holding ciphertext stable until dout_valid & dout_ready.
REQ-024 SHALL, on the DONE edge with dout_ready high, set FSM -> IDLE; the next accept is possible one cycle later at the earliest.
REQ-025 SHALL ignore din_valid and changes on plaintext/key while in RUN or DONE, leaving internal state unaffected.
REQ-026 SHALL ignore dout_ready in IDLE and RUN.
REQ-027 SHALL assert busy exactly while FSM == RUN.

Reset
REQ-028 SHALL, on rst_n low and independent of clk, force FSM = IDLE, round_cnt = 0, state_reg = 0, key_reg = 0, ciphertext = 0, dout_valid = 0 and busy = 0.
REQ-029 SHALL drive din_ready = 1 during and after reset.
REQ-030 SHALL, when reset asserts mid-RUN or in DONE, abandon the operation without producing any output; after release the block accepts a fresh pair normally.

Verification
REQ-031 SHALL pass: plaintext 0, key 0 -> ciphertext 5579C1387B228445, dout_valid 31 edges after accept.
REQ-032 SHALL pass: plaintext 0, key FFFFFFFFFFFFFFFFFFFF -> ciphertext E72C46C0F5945049.
REQ-033 SHALL pass: plaintext FFFFFFFFFFFFFFFF, key 0 -> A112FFC72F68417B; plaintext FFFFFFFFFFFFFFFF, key all-ones -> 3333DCD3213210D2.
REQ-034 SHALL pass: dout_ready held low 10 cycles in DONE -> ciphertext and dout_valid stable, din_ready 0; the new din_valid pulse is ignored.
REQ-035 SHALL pass: rst_n pulsed low at round_cnt == 15 -> all outputs at reset values immediately; the next encryption of vector REQ-031 is still correct.
REQ-036 SHALL pass: back-to-back operations with din_valid and dout_ready tied high -> one result every 33 cycles, each correct, with no lost or duplicated result.

Source files
------------

// File: rtl/present_round_ctrl.sv
// PRESENT-80 iterative encryption core: one round per clock, valid/ready on both sides.
// State | meaning
// IDLE  | waiting for a plaintext/key pair, din_ready high
// RUN   | one round per clock, round_cnt = 1..ROUNDS
// DONE  | ciphertext held until the consumer takes it
module present_round_ctrl #(
    parameter int ROUNDS = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [63:0] plaintext,
    input  logic [79:0] key,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [63:0] ciphertext,
    output logic        busy,
    output logic [4:0]  round_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    fsm_t        fsm_q, fsm_d;
    logic [63:0] st_q, st_d;
    logic [79:0] key_q, key_d;
    logic [4:0]  rc_q, rc_d;
    logic [63:0] ct_q, ct_d;

    logic [63:0] round_out;
    logic [79:0] key_rot;
    logic [79:0] key_next;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = sbox(x[4*n +: 4]);
        end
        return y;
    endfunction

    // Bit i lands at 16*i mod 63; bit 63 is the fixed point.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        y[63] = x[63];
        for (int i = 0; i < 63; i++) begin
            y[(16*i) % 63] = x[i];
        end
        return y;
    endfunction

    always_comb begin
        round_out = p_layer(sbox_layer(st_q ^ key_q[79:16]));
        key_rot   = {key_q[18:0], key_q[79:19]};
        key_next  = key_rot;
        key_next[79:76] = sbox(key_rot[79:76]);
        key_next[19:15] = key_rot[19:15] ^ rc_q;
    end

    always_comb begin
        fsm_d = fsm_q;
        st_d  = st_q;
        key_d = key_q;
        rc_d  = rc_q;
        ct_d  = ct_q;
        case (fsm_q)
            IDLE: begin
                if (din_valid) begin
                    st_d  = plaintext;
                    key_d = key;
                    rc_d  = 5'd1;
                    fsm_d = RUN;
                end
            end
            RUN: begin
                st_d  = round_out;
                key_d = key_next;
                rc_d  = rc_q + 5'd1;
                // Final whitening uses the key produced in this same cycle.
                if (rc_q == LAST_ROUND) begin
                    ct_d  = round_out ^ key_next[79:16];
                    rc_d  = 5'd0;
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (dout_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
                rc_d  = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
            st_q  <= '0;
            key_q <= '0;
            rc_q  <= '0;
            ct_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            key_q <= key_d;
            rc_q  <= rc_d;
            ct_q  <= ct_d;
        end
    end

    assign din_ready  = (fsm_q == IDLE);
    assign dout_valid = (fsm_q == DONE);
    assign busy       = (fsm_q == RUN);
    assign round_cnt  = rc_q;
    assign ciphertext = ct_q;

endmodule

// File: tb/tb_present_round_ctrl.sv
// Directed bench for present_round_ctrl: known-answer vectors, stall, mid-run reset, back-to-back.
module tb_present_round_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [63:0] plaintext = '0;
    logic [79:0] key = '0;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [63:0] ciphertext;
    logic        busy;
    logic [4:0]  round_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    logic [63:0] pt_tab [4];
    logic [79:0] key_tab[4];
    logic [63:0] exp_tab[4];

    present_round_ctrl #(.ROUNDS(31)) dut (
        .clk(clk), .rst_n(rst_n),
        .din_valid(din_valid), .din_ready(din_ready),
        .plaintext(plaintext), .key(key),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .ciphertext(ciphertext), .busy(busy), .round_cnt(round_cnt)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({din_ready, dout_valid, busy, round_cnt} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got rdy/vld/busy/rc=%b/%b/%b/%0d want 1/0/0/0",
                     din_ready, dout_valid, busy, round_cnt);
        end
        tests_run++;
        if (ciphertext !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_ct: got %h want 0", ciphertext);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (din_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_reset: got rdy=%b busy=%b want 1/0", din_ready, busy);
        end
    endtask

    task automatic test_vector(input int idx);
        int edges;
        bit got;
        @(negedge clk);
        tests_run++;
        if (din_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL vec%0d_ready: got din_ready=%b want 1", idx, din_ready);
        end
        plaintext  = pt_tab[idx];
        key        = key_tab[idx];
        din_valid  = 1'b1;
        dout_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        tests_run++;
        if ({busy, din_ready, round_cnt} !== {1'b1, 1'b0, 5'd1}) begin
            tests_failed++;
            $display("FAIL vec%0d_run: got busy/rdy/rc=%b/%b/%0d want 1/0/1",
                     idx, busy, din_ready, round_cnt);
        end
        edges = 0;
        got = 1'b0;
        while (!got && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (dout_valid) got = 1'b1;
        end
        tests_run++;
        if (edges != 31 || !got) begin
            tests_failed++;
            $display("FAIL vec%0d_latency: got %0d edges (valid=%b) want 31", idx, edges, got);
        end
        tests_run++;
        if (ciphertext !== exp_tab[idx]) begin
            tests_failed++;
            $display("FAIL vec%0d_ct: got %h want %h", idx, ciphertext, exp_tab[idx]);
        end
        tests_run++;
        if ({busy, round_cnt, din_ready} !== {1'b0, 5'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL vec%0d_done: got busy/rc/rdy=%b/%0d/%b want 0/0/0",
                     idx, busy, round_cnt, din_ready);
        end
        dout_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dout_ready = 1'b0;
        tests_run++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL vec%0d_pop: got vld=%b rdy=%b want 0/1", idx, dout_valid, din_ready);
        end
    endtask

    task automatic test_stall();
        int waited;
        @(negedge clk);
        plaintext = pt_tab[1];
        key       = key_tab[1];
        din_valid = 1'b1;
        @(posedge clk);
        // Scribble on inputs and raise dout_ready while running; all must be ignored.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            plaintext  = {32'hDEADBEEF, 28'h0, 4'(c)};
            key        = {16'hA5A5, 60'h0, 4'(c)};
            din_valid  = 1'b1;
            dout_ready = 1'b1;
        end
        @(negedge clk);
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        waited = 0;
        while (!dout_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        tests_run++;
        if (dout_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_timeout: got dout_valid=%b want 1", dout_valid);
        end
        for (int c = 0; c < 10; c++) begin
            if (c == 5) begin
                din_valid = 1'b1;
                plaintext = 64'h0123456789ABCDEF;
            end else begin
                din_valid = 1'b0;
            end
            @(negedge clk);
            tests_run++;
            if ({dout_valid, din_ready, busy} !== {1'b1, 1'b0, 1'b0} ||
                ciphertext !== exp_tab[1]) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: got vld/rdy/busy=%b/%b/%b ct=%h want 1/0/0 ct=%h",
                         c, dout_valid, din_ready, busy, ciphertext, exp_tab[1]);
            end
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({dout_valid, din_ready, busy} !== {1'b0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL stall_release: got vld/rdy/busy=%b/%b/%b want 0/1/0",
                     dout_valid, din_ready, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int waited;
        @(negedge clk);
        plaintext = pt_tab[0];
        key       = key_tab[0];
        din_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        waited = 0;
        while (round_cnt != 5'd15 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        tests_run++;
        if (round_cnt !== 5'd15) begin
            tests_failed++;
            $display("FAIL midrst_reach: got round_cnt=%0d want 15", round_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({din_ready, dout_valid, busy, round_cnt} !== {1'b1, 1'b0, 1'b0, 5'd0} ||
            ciphertext !== 64'h0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got rdy/vld/busy/rc=%b/%b/%b/%0d ct=%h want 1/0/0/0 ct=0",
                     din_ready, dout_valid, busy, round_cnt, ciphertext);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            if (dout_valid || busy) begin
                tests_run++;
                tests_failed++;
                $display("FAIL midrst_ghost: got vld=%b busy=%b at cycle %0d want 0/0",
                         dout_valid, busy, c);
                break;
            end
        end
        test_vector(0);
    endtask

    task automatic test_back_to_back();
        int cyc, last, nout, idx_in;
        @(negedge clk);
        idx_in     = 0;
        plaintext  = pt_tab[0];
        key        = key_tab[0];
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        cyc = 0;
        last = 0;
        nout = 0;
        while (nout < 4 && cyc < 200) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (busy && round_cnt == 5'd1) begin
                idx_in++;
                if (idx_in < 4) begin
                    plaintext = pt_tab[idx_in];
                    key       = key_tab[idx_in];
                end else begin
                    din_valid = 1'b0;
                end
            end
            if (dout_valid) begin
                tests_run++;
                if (ciphertext !== exp_tab[nout]) begin
                    tests_failed++;
                    $display("FAIL b2b_ct%0d: got %h want %h", nout, ciphertext, exp_tab[nout]);
                end
                if (nout > 0) begin
                    tests_run++;
                    if (cyc - last != 33) begin
                        tests_failed++;
                        $display("FAIL b2b_period%0d: got %0d cycles want 33", nout, cyc - last);
                    end
                end
                last = cyc;
                nout++;
            end
        end
        din_valid = 1'b0;
        tests_run++;
        if (nout != 4 || idx_in != 4) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d results %0d accepts want 4/4", nout, idx_in);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dout_valid || busy) begin
                tests_run++;
                tests_failed++;
                $display("FAIL b2b_extra: got vld=%b busy=%b after last result want 0/0",
                         dout_valid, busy);
                break;
            end
        end
        dout_ready = 1'b0;
    endtask

    initial begin
        pt_tab[0] = 64'h0;              key_tab[0] = 80'h0;
        exp_tab[0] = 64'h5579C1387B228445;
        pt_tab[1] = 64'h0;              key_tab[1] = {80{1'b1}};
        exp_tab[1] = 64'hE72C46C0F5945049;
        pt_tab[2] = {64{1'b1}};         key_tab[2] = 80'h0;
        exp_tab[2] = 64'hA112FFC72F68417B;
        pt_tab[3] = {64{1'b1}};         key_tab[3] = {80{1'b1}};
        exp_tab[3] = 64'h3333DCD3213210D2;

        test_reset();
        for (int i = 0; i < 4; i++) test_vector(i);
        test_stall();
        test_reset_mid_run();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
